// File: rtl/memory_access_if.sv
// Bundle of the memory_access block's three channels: execute-side input
// handshake, data-bus request/response, and writeback-side output handshake.
// slave  : the memory_access block itself.
// master : the surrounding pipeline / bus environment driving it.
interface memory_access_if;
  // execute side
  logic        in_valid;
  logic        in_ready;
  logic        in_rm;
  logic        in_wm;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_regw;
  logic [31:0] in_pc;
  // data bus
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  // writeback side
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_regw;
  logic [31:0] out_data;
  logic        out_misalign;

  modport slave (
    input  in_valid, in_rm, in_wm, in_addr, in_wdata, in_regw, in_pc,
    output in_ready,
    output dreq_valid, dreq_addr, dreq_strobe, dreq_data,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    output out_valid, out_pc, out_regw, out_data, out_misalign,
    input  out_ready
  );

  modport master (
    output in_valid, in_rm, in_wm, in_addr, in_wdata, in_regw, in_pc,
    input  in_ready,
    input  dreq_valid, dreq_addr, dreq_strobe, dreq_data,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    input  out_valid, out_pc, out_regw, out_data, out_misalign,
    output out_ready
  );
endinterface

// File: rtl/memory_access.sv
// memory_access: MEM pipeline stage. Registers an execute result, issues a
// single-word load/store on the data bus when needed, and presents the
// writeback result with a valid/ready handshake.
// Optional feature: define MEMORY_ACCESS_MISALIGN_CHECK_EN to trap memory ops
// whose address is not word aligned (no bus request, out_misalign=1).
module memory_access (
  input  logic           clk,
  input  logic           reset,
  memory_access_if.slave mif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [1:0]  accept_state;
  logic [29:0] waddr_r;
  logic [31:0] wdata_r;
  logic [31:0] pc_r;
  logic [31:0] data_r;
  logic [4:0]  regw_r;
  logic        load_r;
  logic        store_r;
  logic        accept;
  logic        in_mem;
  logic        in_store;
  logic        in_misalign;
  logic        data_done;

  // in_rm has priority, so rm&wm together behaves as a load
  assign in_mem   = mif.in_rm | mif.in_wm;
  assign in_store = mif.in_wm & ~mif.in_rm;

`ifdef MEMORY_ACCESS_MISALIGN_CHECK_EN
  logic misalign_r;
  assign in_misalign      = in_mem & (mif.in_addr[1:0] != 2'b00);
  assign mif.out_misalign = misalign_r;
`else
  assign in_misalign      = 1'b0;
  assign mif.out_misalign = 1'b0;
`endif

  assign mif.in_ready = (state == IDLE) || ((state == DONE) && mif.out_ready);
  assign accept       = mif.in_valid & mif.in_ready;

  // data_ok only counts once the request has been (or is being) accepted
  assign data_done = mif.dresp_data_ok &
                     ((state == WAIT) || ((state == REQ) && mif.dresp_addr_ok));

  assign accept_state = (in_mem & ~in_misalign) ? REQ : DONE;

  assign mif.dreq_valid  = (state == REQ);
  assign mif.dreq_addr   = {waddr_r, 2'b00};
  assign mif.dreq_strobe = store_r ? 4'hF : 4'h0;
  assign mif.dreq_data   = wdata_r;
  assign mif.out_valid   = (state == DONE);
  assign mif.out_pc      = pc_r;
  assign mif.out_regw    = regw_r;
  assign mif.out_data    = data_r;

  // next-state selection for the IDLE/REQ/WAIT/DONE sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = accept_state;
      REQ:  if (mif.dresp_addr_ok) state_nxt = mif.dresp_data_ok ? DONE : WAIT;
      WAIT: if (mif.dresp_data_ok) state_nxt = DONE;
      DONE: if (mif.out_ready) state_nxt = accept ? accept_state : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state register; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // capture the accepted op and prefill the writeback value; load data lands on data_ok
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waddr_r <= '0;
      wdata_r <= '0;
      pc_r    <= '0;
      data_r  <= '0;
      regw_r  <= '0;
      load_r  <= 1'b0;
      store_r <= 1'b0;
    end else if (accept) begin
      waddr_r <= mif.in_addr[31:2];
      wdata_r <= mif.in_wdata;
      pc_r    <= mif.in_pc;
      data_r  <= (in_mem & ~in_misalign) ? 32'd0 : mif.in_addr;
      regw_r  <= (in_store | in_misalign) ? 5'd0 : mif.in_regw;
      load_r  <= mif.in_rm;
      store_r <= in_store & ~in_misalign;
    end else if (data_done && load_r) begin
      data_r  <= mif.dresp_data;
    end
  end

`ifdef MEMORY_ACCESS_MISALIGN_CHECK_EN
  // address-error flag follows each accepted op
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       misalign_r <= 1'b0;
    else if (accept) misalign_r <= in_misalign;
  end
`endif

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed cases followed by randomized
// ops, each compared against a transaction-level reference model.
module tb_memory_access;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  memory_access_if mif ();
  memory_access dut (.clk(clk), .reset(reset), .mif(mif));

  int n_cmp = 0;
  int n_err = 0;

`ifdef MEMORY_ACCESS_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  regw;
    logic        mis;
    logic        bus;
    logic [3:0]  strobe;
    logic [31:0] baddr;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one op, straight from the load/store/ALU rules.
  function automatic exp_t model(input logic rm, input logic wm, input logic [31:0] addr,
                                 input logic [4:0] regw, input logic [31:0] rdata);
    exp_t e;
    logic is_mem, is_load, is_store;
    is_mem   = rm | wm;
    is_load  = rm;
    is_store = wm & ~rm;
    e.mis    = MIS_EN && is_mem && (addr % 4 != 0);
    e.bus    = is_mem && !e.mis;
    e.strobe = is_store ? 4'hF : 4'h0;
    e.baddr  = addr - (addr % 4);
    if (e.mis)         e.data = addr;
    else if (is_load)  e.data = rdata;
    else if (is_store) e.data = 32'd0;
    else               e.data = addr;
    e.regw = (is_store || e.mis) ? 5'd0 : regw;
    return e;
  endfunction

  task automatic idle_inputs();
    mif.in_valid = 0; mif.in_rm = 0; mif.in_wm = 0;
    mif.in_addr = 0; mif.in_wdata = 0; mif.in_regw = 0; mif.in_pc = 0;
    mif.dresp_addr_ok = 0; mif.dresp_data_ok = 0; mif.dresp_data = 0;
    mif.out_ready = 0;
  endtask

  // One complete transaction starting from IDLE, ending back in IDLE.
  task automatic run_op(input string tag, input logic rm, input logic wm,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] regw, input logic [31:0] pc,
                        input logic [31:0] rdata, input int aok, input int dok, input int rdy);
    exp_t e;
    e = model(rm, wm, addr, regw, rdata);
    @(negedge clk);
    mif.in_valid = 1; mif.in_rm = rm; mif.in_wm = wm; mif.in_addr = addr;
    mif.in_wdata = wdata; mif.in_regw = regw; mif.in_pc = pc;
    mif.dresp_data_ok = 1; mif.dresp_data = $urandom;   // must be ignored in IDLE
    #1 chk({tag, "/in_ready_idle"}, mif.in_ready, 1);
    @(negedge clk);
    mif.in_valid = 0; mif.in_rm = $urandom; mif.in_wm = $urandom;
    mif.in_addr = $urandom; mif.in_wdata = $urandom; mif.in_regw = $urandom; mif.in_pc = $urandom;
    mif.dresp_data_ok = 0; mif.dresp_data = $urandom;
    if (e.bus) begin
      for (int c = 0; c <= aok; c++) begin
        #1;
        chk({tag, "/dreq_valid"}, mif.dreq_valid, 1);
        chk({tag, "/dreq_addr"}, mif.dreq_addr, e.baddr);
        chk({tag, "/dreq_strobe"}, mif.dreq_strobe, e.strobe);
        chk({tag, "/dreq_data"}, mif.dreq_data, wdata);
        chk({tag, "/out_valid_req"}, mif.out_valid, 0);
        if (c == aok) begin
          mif.dresp_addr_ok = 1; mif.dresp_data_ok = (dok == 0); mif.dresp_data = rdata;
        end
        @(negedge clk);
        mif.dresp_addr_ok = 0; mif.dresp_data_ok = 0; mif.dresp_data = $urandom;
      end
      for (int d = 0; d < dok; d++) begin
        #1;
        chk({tag, "/dreq_valid_wait"}, mif.dreq_valid, 0);
        chk({tag, "/out_valid_wait"}, mif.out_valid, 0);
        if (d == dok - 1) begin
          mif.dresp_data_ok = 1; mif.dresp_data = rdata;
        end
        @(negedge clk);
        mif.dresp_data_ok = 0; mif.dresp_data = $urandom;
      end
    end
    for (int r = 0; r <= rdy; r++) begin
      mif.out_ready = (r == rdy);
      mif.dresp_data_ok = 1; mif.dresp_data = $urandom;   // must be ignored in DONE
      #1;
      chk({tag, "/out_valid"}, mif.out_valid, 1);
      chk({tag, "/out_data"}, mif.out_data, e.data);
      chk({tag, "/out_regw"}, mif.out_regw, e.regw);
      chk({tag, "/out_pc"}, mif.out_pc, pc);
      chk({tag, "/out_misalign"}, mif.out_misalign, e.mis);
      chk({tag, "/dreq_valid_done"}, mif.dreq_valid, 0);
      chk({tag, "/in_ready_done"}, mif.in_ready, (r == rdy));
      @(negedge clk);
    end
    mif.out_ready = 0; mif.dresp_data_ok = 0;
    #1;
    chk({tag, "/out_valid_after"}, mif.out_valid, 0);
    chk({tag, "/in_ready_after"}, mif.in_ready, 1);
  endtask

  logic [31:0] b2b_addr [8];
  logic [4:0]  b2b_regw [8];
  logic [31:0] b2b_pc   [8];

  initial begin
    idle_inputs();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst/dreq_valid", mif.dreq_valid, 0);
    chk("rst/out_valid", mif.out_valid, 0);
    chk("rst/out_misalign", mif.out_misalign, 0);
    chk("rst/dreq_strobe", mif.dreq_strobe, 0);
    chk("rst/out_regw", mif.out_regw, 0);
    chk("rst/out_data", mif.out_data, 0);
    chk("rst/out_pc", mif.out_pc, 0);
    chk("rst/dreq_addr", mif.dreq_addr, 0);
    chk("rst/dreq_data", mif.dreq_data, 0);
    @(negedge clk);
    reset = 0;
    #1 chk("rst/in_ready_first", mif.in_ready, 1);

    // directed cases
    run_op("addu", 0, 0, 32'h0000_1234, 32'h5555_0000, 5'd5, 32'hBFC0_0000, 32'h0, 0, 0, 0);
    run_op("load_slow", 1, 0, 32'h8000_0010, 32'h0, 5'd9, 32'hBFC0_0004, 32'hDEAD_BEEF, 2, 1, 0);
    run_op("store_fast", 0, 1, 32'h0000_0100, 32'hA5A5_A5A5, 5'd7, 32'hBFC0_0008, 32'h1111_2222, 0, 0, 0);
    run_op("hold3", 0, 0, 32'hCAFE_0000, 32'h0, 5'd31, 32'hBFC0_000C, 32'h0, 0, 0, 3);
    run_op("rm_wm_load", 1, 1, 32'h0000_0200, 32'h7777_7777, 5'd3, 32'hBFC0_0010, 32'h0BAD_F00D, 1, 2, 1);
    run_op("mis_load", 1, 0, 32'h0000_0102, 32'h0, 5'd4, 32'hBFC0_0014, 32'h1122_3344, 1, 0, 0);
    run_op("mis_store", 0, 1, 32'h0000_0203, 32'hFFFF_0000, 5'd6, 32'hBFC0_0018, 32'h0, 0, 1, 1);

    // back-to-back non-memory ops: one per cycle, DONE accepts directly
    for (int k = 0; k < 8; k++) begin
      b2b_addr[k] = $urandom; b2b_regw[k] = 5'($urandom); b2b_pc[k] = $urandom;
    end
    @(negedge clk);
    mif.out_ready = 1;
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        mif.in_valid = 1; mif.in_rm = 0; mif.in_wm = 0;
        mif.in_addr = b2b_addr[k]; mif.in_regw = b2b_regw[k]; mif.in_pc = b2b_pc[k];
      end else begin
        mif.in_valid = 0;
      end
      #1;
      if (k < 8) chk("b2b/in_ready", mif.in_ready, 1);
      if (k > 0) begin
        chk("b2b/out_valid", mif.out_valid, 1);
        chk("b2b/out_data", mif.out_data, b2b_addr[k-1]);
        chk("b2b/out_regw", mif.out_regw, b2b_regw[k-1]);
        chk("b2b/out_pc", mif.out_pc, b2b_pc[k-1]);
      end
      @(negedge clk);
    end
    mif.out_ready = 0;
    #1 chk("b2b/out_valid_end", mif.out_valid, 0);

    // reset while waiting for data_ok abandons the load
    @(negedge clk);
    mif.in_valid = 1; mif.in_rm = 1; mif.in_wm = 0; mif.in_addr = 32'h8000_0020;
    mif.in_regw = 5'd12; mif.in_pc = 32'hBFC0_0100;
    @(negedge clk);
    mif.in_valid = 0;
    #1 chk("rstw/dreq_valid", mif.dreq_valid, 1);
    mif.dresp_addr_ok = 1;
    @(negedge clk);
    mif.dresp_addr_ok = 0;
    #1;
    chk("rstw/in_wait_dreq", mif.dreq_valid, 0);
    chk("rstw/in_wait_out_valid", mif.out_valid, 0);
    reset = 1;
    #1;
    chk("rstw/async_out_valid", mif.out_valid, 0);
    chk("rstw/async_out_pc", mif.out_pc, 0);
    chk("rstw/async_dreq_addr", mif.dreq_addr, 0);
    chk("rstw/async_out_regw", mif.out_regw, 0);
    @(negedge clk);
    reset = 0;
    #1 chk("rstw/in_ready_first", mif.in_ready, 1);
    mif.dresp_data_ok = 1; mif.dresp_data = 32'h5A5A_5A5A;
    @(negedge clk);
    mif.dresp_data_ok = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("rstw/out_valid_late", mif.out_valid, 0);
      chk("rstw/dreq_valid_late", mif.dreq_valid, 0);
      chk("rstw/in_ready_late", mif.in_ready, 1);
      chk("rstw/out_data_late", mif.out_data, 0);
      @(negedge clk);
    end

    // randomized ops
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      run_op($sformatf("rnd%0d", i), op[1], op[0], a, $urandom, 5'($urandom), $urandom,
             $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
